// File: rtl/canvas_painter.sv
// canvas_painter: 28x28 digit canvas written by a plus-shaped brush.
// Once per frame the cursor cell and the paint/erase buttons are sampled. A stamp then
// updates the centre cell and its four neighbours, one cell per cycle, using saturating
// arithmetic. A clear request zeroes the canvas one row per cycle.
// Ports:
//   Clk         system clock
//   Reset       synchronous, active-low reset
//   frame_tick  one-cycle pulse at the start of each frame
//   CurX, CurY  cursor pixel coordinates
//   paint       level, add ink
//   erase       level, remove ink (ignored while paint=1)
//   clear       one-cycle pulse, zero the entire canvas
//   canvas      cell intensities, canvas[x][y] is 16 bits
//   busy        high while a stamp or a clear is in progress
module canvas_painter #(
  parameter int unsigned X0      = 199,
  parameter int unsigned Y0      = 43,
  parameter int unsigned CELL    = 14,
  parameter int unsigned N       = 28,
  parameter logic [15:0] INK_C   = 16'h0200,
  parameter logic [15:0] INK_E   = 16'h0080,
  parameter logic [15:0] INK_MAX = 16'h07FF
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_tick,
  input  logic [9:0]                  CurX,
  input  logic [9:0]                  CurY,
  input  logic                        paint,
  input  logic                        erase,
  input  logic                        clear,
  output logic [N-1:0][N-1:0][15:0]   canvas,
  output logic                        busy
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StStamp, StClear} state_e;

  state_e                      r_state, w_state_d;
  logic [N-1:0][N-1:0][15:0]   r_canvas;
  logic                        r_busy;
  logic                        r_pending;
  logic                        r_mode;     // 1: add ink, 0: remove ink
  logic [2:0]                  r_idx;
  logic [IW-1:0]               r_row;
  logic [IW-1:0]               r_cx, r_cy;

  logic [IW-1:0]               w_cx, w_cy;
  logic                        w_in_win;
  logic [IW-1:0]               w_tx, w_ty;
  logic                        w_tval;
  logic [15:0]                 w_delta, w_cell, w_new;
  logic [16:0]                 w_sum;
  logic                        w_start_stamp, w_start_clear;

  // Pixel to cell mapping as a compare chain: the last boundary passed wins.
  always_comb begin
    w_cx = '0;
    w_cy = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(CurX) >= X0 + k * CELL) w_cx = IW'(k);
      if (32'(CurY) >= Y0 + k * CELL) w_cy = IW'(k);
    end
    w_in_win = (32'(CurX) >= X0) && (32'(CurX) < X0 + N * CELL) &&
               (32'(CurY) >= Y0) && (32'(CurY) < Y0 + N * CELL);
  end

  // Brush target for the current stamp step; off-canvas neighbours are masked, not skipped.
  always_comb begin
    w_tx    = r_cx;
    w_ty    = r_cy;
    w_tval  = 1'b1;
    w_delta = INK_E;
    case (r_idx)
      3'd0: w_delta = INK_C;
      3'd1: begin
        w_ty   = r_cy - 1'b1;
        w_tval = (r_cy != '0);
      end
      3'd2: begin
        w_ty   = r_cy + 1'b1;
        w_tval = (r_cy != IW'(N - 1));
      end
      3'd3: begin
        w_tx   = r_cx - 1'b1;
        w_tval = (r_cx != '0);
      end
      3'd4: begin
        w_tx   = r_cx + 1'b1;
        w_tval = (r_cx != IW'(N - 1));
      end
      default: w_tval = 1'b0;
    endcase
  end

  always_comb begin
    w_cell = '0;
    if (w_tval) w_cell = r_canvas[w_tx][w_ty];
    w_sum = {1'b0, w_cell} + {1'b0, w_delta};
    if (r_mode) begin
      w_new = (w_sum > {1'b0, INK_MAX}) ? INK_MAX : w_sum[15:0];
    end else begin
      w_new = (w_cell > w_delta) ? (w_cell - w_delta) : '0;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_start_stamp = 1'b0;
    w_start_clear = 1'b0;
    case (r_state)
      StIdle: begin
        if (clear || r_pending) begin
          w_state_d     = StClear;
          w_start_clear = 1'b1;
        end else if (frame_tick && (paint || erase) && w_in_win) begin
          w_state_d     = StStamp;
          w_start_stamp = 1'b1;
        end
      end
      StStamp: if (r_idx == 3'd4) w_state_d = StIdle;
      StClear: if (r_row == IW'(N - 1)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= StIdle;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
      r_canvas  <= '0;
      r_mode    <= 1'b0;
      r_idx     <= '0;
      r_row     <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= (w_state_d != StIdle);

      if (w_start_stamp) begin
        r_cx   <= w_cx;
        r_cy   <= w_cy;
        r_mode <= paint;
        r_idx  <= '0;
      end else if (r_state == StStamp) begin
        r_idx <= r_idx + 3'd1;
      end

      // A clear seen mid-stamp is remembered; one seen mid-clear is dropped.
      if (w_start_clear) begin
        r_row     <= '0;
        r_pending <= 1'b0;
      end else if (r_state == StClear) begin
        r_row <= r_row + 1'b1;
      end else if (r_state == StStamp && clear) begin
        r_pending <= 1'b1;
      end

      if (r_state == StStamp && w_tval) r_canvas[w_tx][w_ty] <= w_new;

      if (r_state == StClear) begin
        for (int x = 0; x < int'(N); x++) r_canvas[x][r_row] <= '0;
      end
    end
  end

  assign canvas = r_canvas;
  assign busy   = r_busy;

endmodule

// File: tb/tb_canvas_painter.sv
// Scoreboard bench for canvas_painter: stimulus queues the expected busy-run length and cell
// values of each operation; a monitor checks them when busy drops.
module tb_canvas_painter;

  localparam int N = 28;

  logic                      Clk = 1'b0;
  logic                      Reset = 1'b0;
  logic                      frame_tick = 1'b0;
  logic [9:0]                CurX = '0;
  logic [9:0]                CurY = '0;
  logic                      paint = 1'b0;
  logic                      erase = 1'b0;
  logic                      clear = 1'b0;
  logic [N-1:0][N-1:0][15:0] canvas;
  logic                      busy;

  canvas_painter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .CurX       (CurX),
    .CurY       (CurY),
    .paint      (paint),
    .erase      (erase),
    .clear      (clear),
    .canvas     (canvas),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {int id; string name; int len;} op_t;
  // x < 0 means "whole canvas must be zero"
  typedef struct {int id; string name; int x; int y; int v;} cell_t;

  op_t   oq[$];
  cell_t cq[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    next_id = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nonzero();
    int n = 0;
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        if (canvas[x][y] != 16'h0) n++;
    return n;
  endfunction

  function automatic int push_op(input string name, input int len);
    op_t o;
    o.id = next_id;
    o.name = name;
    o.len = len;
    oq.push_back(o);
    next_id++;
    return o.id;
  endfunction

  task automatic push_cell(input int id, input string name, input int x, input int y,
                           input int v);
    cell_t c;
    c.id = id;
    c.name = name;
    c.x = x;
    c.y = y;
    c.v = v;
    cq.push_back(c);
  endtask

  // Monitor: measures each busy run and checks the entries queued for that operation.
  int    run = 0;
  op_t   mo;
  cell_t mc;
  always @(negedge Clk) begin
    if (busy) begin
      run++;
    end else if (run > 0) begin
      if (oq.size() == 0) begin
        chk("unexpected_busy_run", run, 0);
      end else begin
        mo = oq.pop_front();
        chk({mo.name, "_busy_len"}, run, mo.len);
        while (cq.size() > 0 && cq[0].id == mo.id) begin
          mc = cq.pop_front();
          if (mc.x < 0) chk(mc.name, nonzero(), 0);
          else chk(mc.name, int'(canvas[mc.x][mc.y]), mc.v);
        end
      end
      run = 0;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (!busy) return;
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic frame();
    @(posedge Clk);
    #1 frame_tick = 1'b1;
    @(posedge Clk);
    #1 frame_tick = 1'b0;
    wait_idle();
  endtask

  initial begin
    int id;
    int bc;

    // 1: reset
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_canvas_zero", nonzero(), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge Clk);
    #1 Reset = 1'b1;

    // 2: single paint stamp at cell (5,7)
    CurX = 10'd272;
    CurY = 10'd141;
    paint = 1'b1;
    id = push_op("t2_stamp", 5);
    push_cell(id, "t2_c57", 5, 7, 'h200);
    push_cell(id, "t2_c56", 5, 6, 'h080);
    push_cell(id, "t2_c58", 5, 8, 'h080);
    push_cell(id, "t2_c47", 4, 7, 'h080);
    push_cell(id, "t2_c67", 6, 7, 'h080);
    push_cell(id, "t2_c55", 5, 5, 'h000);
    frame();
    paint = 1'b0;

    // 4: erase twice, no underflow wrap
    erase = 1'b1;
    void'(push_op("t4_erase1", 5));
    frame();
    id = push_op("t4_erase2", 5);
    push_cell(id, "t4_c57", 5, 7, 0);
    push_cell(id, "t4_c56", 5, 6, 0);
    push_cell(id, "t4_c58", 5, 8, 0);
    push_cell(id, "t4_c47", 4, 7, 0);
    push_cell(id, "t4_c67", 6, 7, 0);
    frame();
    erase = 1'b0;

    // 3: six paints at the corner cell, saturation and edge masking
    CurX = 10'd199;
    CurY = 10'd43;
    paint = 1'b1;
    for (int i = 0; i < 5; i++) begin
      void'(push_op("t3_stamp", 5));
      frame();
    end
    id = push_op("t3_stamp6", 5);
    push_cell(id, "t3_c00_sat", 0, 0, 'h7FF);
    push_cell(id, "t3_c10", 1, 0, 'h300);
    push_cell(id, "t3_c01", 0, 1, 'h300);
    push_cell(id, "t3_c11", 1, 1, 0);
    push_cell(id, "t3_c27_0", 27, 0, 0);
    push_cell(id, "t3_c0_27", 0, 27, 0);
    frame();

    // 5: clear two cycles after a stamp trigger is deferred until the stamp ends
    void'(push_op("t5_stamp", 5));
    id = push_op("t5_clear", 28);
    push_cell(id, "t5_all_zero", -1, 0, 0);
    @(posedge Clk);
    #1 frame_tick = 1'b1;
    @(posedge Clk);
    #1 frame_tick = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 clear = 1'b1;
    @(posedge Clk);
    #1 clear = 1'b0;
    paint = 1'b0;
    repeat (40) @(negedge Clk);

    // 6a: reset at row 10 of a clear wipes a stamp in rows 19..21
    CurX = 10'd272;
    CurY = 10'd323;
    paint = 1'b1;
    void'(push_op("t6_stamp", 5));
    frame();
    paint = 1'b0;
    id = push_op("t6_clear_reset", 11);
    push_cell(id, "t6_clear_reset_zero", -1, 0, 0);
    @(posedge Clk);
    #1 clear = 1'b1;
    @(posedge Clk);
    #1 clear = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);

    // 6b: reset at idx 2 of a stamp
    paint = 1'b1;
    id = push_op("t6_stamp_reset", 3);
    push_cell(id, "t6_stamp_reset_zero", -1, 0, 0);
    @(posedge Clk);
    #1 frame_tick = 1'b1;
    @(posedge Clk);
    #1 frame_tick = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);

    // 6c: cursor left of the canvas never starts a stamp
    CurX = 10'd150;
    CurY = 10'd141;
    @(posedge Clk);
    #1 frame_tick = 1'b1;
    @(posedge Clk);
    #1 frame_tick = 1'b0;
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (busy) bc++;
    end
    chk("t6_offcanvas_busy_cycles", bc, 0);
    chk("t6_offcanvas_zero", nonzero(), 0);
    paint = 1'b0;

    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", oq.size() + cq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
